// File: rtl/bist_engine.sv
// BIST sequencer: stores stimulus/expected/mask vectors, replays them and compares masked responses.
// Latency: vector k is driven at start+1+k; its response is compared LAT cycles later.
// Backpressure: loads are accepted only in IDLE while not full; a load attempt when full sets overflow.
module bist_engine #(
  parameter int DEPTH    = 256,
  parameter int STIM_W   = 4,
  parameter int RESP_W   = 4,
  parameter int LAT      = 1,
  parameter int ERRCNT_W = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  input  logic [STIM_W-1:0]   load_stim,
  input  logic [RESP_W-1:0]   load_exp,
  input  logic [RESP_W-1:0]   load_mask,
  input  logic                load_clear,
  output logic                load_ready,
  output logic                overflow,
  output logic [AW:0]         vec_count,
  input  logic                start,
  input  logic                stop_on_fail,
  input  logic                abort,
  output logic [STIM_W-1:0]   bist_out,
  output logic                bist_out_valid,
  input  logic [RESP_W-1:0]   bist_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERRCNT_W-1:0] fail_count,
  output logic [AW-1:0]       first_fail_addr,
  output logic [RESP_W-1:0]   first_fail_data,
  output logic                first_fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [AW:0]         vec_count_q, vec_count_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                sof_q, sof_d;
  logic [STIM_W-1:0]   bout_q, bout_d;
  logic                bout_vld_q, bout_vld_d;
  logic [AW-1:0]       cur_addr_q, cur_addr_d;
  logic [LAT-1:0]      pv_q, pv_d;
  logic [AW-1:0]       pa_q [LAT];
  logic [AW-1:0]       pa_d [LAT];
  logic [ERRCNT_W-1:0] fc_q, fc_d;
  logic [AW-1:0]       ffa_q, ffa_d;
  logic [RESP_W-1:0]   ffd_q, ffd_d;
  logic                ffv_q, ffv_d;
  logic                pass_q, pass_d;
  logic                mem_we;

  logic [STIM_W-1:0]   stim_mem [DEPTH];
  logic [RESP_W-1:0]   exp_mem  [DEPTH];
  logic [RESP_W-1:0]   mask_mem [DEPTH];

  logic active, full, mismatch;
  assign active   = (state_q == RUN) || (state_q == DRAIN);
  assign full     = (vec_count_q == DEPTH_C);
  // The tail of the tag pipeline lines up with the response of the vector it names.
  assign mismatch = pv_q[LAT-1] &&
                    (|((bist_in ^ exp_mem[pa_q[LAT-1]]) & mask_mem[pa_q[LAT-1]]));

  // Next-state, issue, compare and status logic.
  always_comb begin
    state_d     = state_q;
    vec_count_d = vec_count_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    sof_d       = sof_q;
    bout_d      = '0;
    bout_vld_d  = 1'b0;
    cur_addr_d  = cur_addr_q;
    fc_d        = fc_q;
    ffa_d       = ffa_q;
    ffd_d       = ffd_q;
    ffv_d       = ffv_q;
    pass_d      = pass_q;
    mem_we      = 1'b0;

    // Tag pipeline follows whatever is on bist_out this cycle.
    pv_d[0] = bout_vld_q;
    pa_d[0] = cur_addr_q;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
    end

    if (active && mismatch) begin
      if (fc_q != '1) fc_d = fc_q + ERRCNT_W'(1);
      if (!ffv_q) begin
        ffv_d = 1'b1;
        ffa_d = pa_q[LAT-1];
        ffd_d = bist_in;
      end
    end

    case (state_q)
      IDLE: begin
        if (load_clear) begin
          vec_count_d = '0;
          overflow_d  = 1'b0;
        end else if (load_valid && !full) begin
          mem_we      = 1'b1;
          vec_count_d = vec_count_q + (AW+1)'(1);
        end else begin
          if (load_valid) overflow_d = 1'b1;
          if (start) begin
            fc_d   = '0;
            ffv_d  = 1'b0;
            ffa_d  = '0;
            ffd_d  = '0;
            pass_d = 1'b0;
            sof_d  = stop_on_fail;
            if (vec_count_q == '0) begin
              state_d = DONE;
            end else begin
              state_d    = RUN;
              bout_d     = stim_mem[0];
              bout_vld_d = 1'b1;
              cur_addr_d = '0;
              rd_ptr_d   = (AW+1)'(1);
            end
          end
        end
      end
      RUN: begin
        if (mismatch && sof_q) begin
          state_d = DRAIN;
        end else if (rd_ptr_q < vec_count_q) begin
          bout_d     = stim_mem[rd_ptr_q[AW-1:0]];
          bout_vld_d = 1'b1;
          cur_addr_d = rd_ptr_q[AW-1:0];
          rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pv_d == '0) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // pass becomes valid on the cycle DONE is entered and holds until the next start.
    if (state_d == DONE && state_q != DONE) pass_d = (fc_d == '0);

    if (abort && active) begin
      state_d    = IDLE;
      bout_d     = '0;
      bout_vld_d = 1'b0;
      pv_d       = '0;
      pass_d     = 1'b0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_count_q <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      sof_q       <= 1'b0;
      bout_q      <= '0;
      bout_vld_q  <= 1'b0;
      cur_addr_q  <= '0;
      pv_q        <= '0;
      for (int i = 0; i < LAT; i++) pa_q[i] <= '0;
      fc_q        <= '0;
      ffa_q       <= '0;
      ffd_q       <= '0;
      ffv_q       <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_count_q <= vec_count_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      sof_q       <= sof_d;
      bout_q      <= bout_d;
      bout_vld_q  <= bout_vld_d;
      cur_addr_q  <= cur_addr_d;
      pv_q        <= pv_d;
      for (int i = 0; i < LAT; i++) pa_q[i] <= pa_d[i];
      fc_q        <= fc_d;
      ffa_q       <= ffa_d;
      ffd_q       <= ffd_d;
      ffv_q       <= ffv_d;
      pass_q      <= pass_d;
    end
  end

  // Vector memory is not reset; only written while loading in IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      stim_mem[vec_count_q[AW-1:0]] <= load_stim;
      exp_mem[vec_count_q[AW-1:0]]  <= load_exp;
      mask_mem[vec_count_q[AW-1:0]] <= load_mask;
    end
  end

  assign load_ready       = (state_q == IDLE) && !full;
  assign overflow         = overflow_q;
  assign vec_count        = vec_count_q;
  assign bist_out         = bout_q;
  assign bist_out_valid   = bout_vld_q;
  assign busy             = active;
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign fail_count       = fc_q;
  assign first_fail_addr  = ffa_q;
  assign first_fail_data  = ffd_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench: two engines (LAT=1 and LAT=3, DEPTH=8) share stimulus; each gets its own DUT echo model.
module tb_bist_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0, load_clear = 1'b0;
  logic [3:0] load_stim = '0, load_exp = '0, load_mask = '0;
  logic       start = 1'b0, stop_on_fail = 1'b0, abort = 1'b0;
  logic [3:0] bin1, bin3;
  int         mode = 0;

  logic       lr1, ovf1, bov1, busy1, done1, pass1, ffv1;
  logic [3:0] vc1, bo1, fc1_n, ffd1;
  logic [7:0] fc1;
  logic [2:0] ffa1;
  logic       lr3, ovf3, bov3, busy3, done3, pass3, ffv3;
  logic [3:0] vc3, bo3, ffd3;
  logic [7:0] fc3;
  logic [2:0] ffa3;

  int checks = 0, failures = 0, nd1 = 0, nd3 = 0;

  bist_engine #(.DEPTH(8), .STIM_W(4), .RESP_W(4), .LAT(1), .ERRCNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_stim(load_stim),
    .load_exp(load_exp), .load_mask(load_mask), .load_clear(load_clear),
    .load_ready(lr1), .overflow(ovf1), .vec_count(vc1), .start(start),
    .stop_on_fail(stop_on_fail), .abort(abort), .bist_out(bo1), .bist_out_valid(bov1),
    .bist_in(bin1), .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
    .first_fail_addr(ffa1), .first_fail_data(ffd1), .first_fail_valid(ffv1));

  bist_engine #(.DEPTH(8), .STIM_W(4), .RESP_W(4), .LAT(3), .ERRCNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_stim(load_stim),
    .load_exp(load_exp), .load_mask(load_mask), .load_clear(load_clear),
    .load_ready(lr3), .overflow(ovf3), .vec_count(vc3), .start(start),
    .stop_on_fail(stop_on_fail), .abort(abort), .bist_out(bo3), .bist_out_valid(bov3),
    .bist_in(bin3), .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3),
    .first_fail_addr(ffa3), .first_fail_data(ffd3), .first_fail_valid(ffv3));

  // DUT response model: expected value is stim+8; modes inject specific corruptions.
  function automatic logic [3:0] resp(input logic [3:0] s, input int m);
    logic [3:0] e;
    e = s + 4'd8;
    case (m)
      1:       return (s == 4'd3) ? 4'd0 : e;
      2:       return e ^ 4'h1;
      3:       return (s == 4'd2) ? (e ^ 4'h8) : e;
      default: return e;
    endcase
  endfunction

  logic [3:0] h1;
  logic [3:0] h3 [3];
  always @(posedge clk) begin
    h1    <= bo1;
    h3[0] <= bo3;
    h3[1] <= h3[0];
    h3[2] <= h3[1];
  end
  assign bin1 = resp(h1, mode);
  assign bin3 = resp(h3[2], mode);
  assign fc1_n = fc1[3:0];

  task automatic tick();
    @(posedge clk);
    #1;
    if (done1) nd1++;
    if (done3) nd3++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] s, input logic [3:0] e, input logic [3:0] m);
    load_valid = 1'b1; load_stim = s; load_exp = e; load_mask = m;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic clear();
    load_clear = 1'b1;
    tick();
    load_clear = 1'b0;
  endtask

  // Pulse start; on return the bench sits in cycle S+1.
  task automatic go(input logic sof);
    nd1 = 0; nd3 = 0;
    stop_on_fail = sof; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick(); tick();
    // Reset state
    chk("rst_vec_count", vc1, 0);
    chk("rst_overflow", ovf1, 0);
    chk("rst_bist_out", bo1, 0);
    chk("rst_out_valid", bov1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_fail_count", fc1, 0);
    chk("rst_ff_valid", ffv1, 0);
    chk("rst_load_ready", lr1, 1);
    rst_n = 1'b1;
    tick();

    // Four vectors, clean echo, run to end
    for (int i = 0; i < 4; i++) load(4'(i + 1), 4'(i + 9), 4'hF);
    chk("load4_vec_count", vc1, 4);
    mode = 0;
    go(1'b0);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("clean_done1_c%0d", c), done1, (c == 6));
      chk($sformatf("clean_busy1_c%0d", c), busy1, (c <= 5));
      chk($sformatf("clean_vld1_c%0d", c), bov1, (c <= 4));
      chk($sformatf("clean_done3_c%0d", c), done3, (c == 8));
      if (c <= 4) chk($sformatf("clean_out1_c%0d", c), bo1, c);
      if (c == 6) begin
        chk("clean_pass1", pass1, 1);
        chk("clean_fc1", fc1, 0);
      end
      tick();
    end
    chk("clean_pass3", pass3, 1);
    chk("clean_ndone1", nd1, 1);
    chk("clean_ndone3", nd3, 1);

    // Vector 2 corrupted to 0, run to end
    mode = 1;
    go(1'b0);
    repeat (12) tick();
    chk("corrupt_pass1", pass1, 0);
    chk("corrupt_fc1", fc1, 1);
    chk("corrupt_ffa1", ffa1, 2);
    chk("corrupt_ffd1", ffd1, 0);
    chk("corrupt_ffv1", ffv1, 1);
    chk("corrupt_fc3", fc3, 1);
    chk("corrupt_ffa3", ffa3, 2);
    chk("corrupt_ndone3", nd3, 1);

    // Stop on first fail, every response wrong, eight vectors
    clear();
    for (int i = 0; i < 8; i++) load(4'(i + 1), 4'(i + 9), 4'hF);
    mode = 2;
    go(1'b1);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("sof_vld1_c%0d", c), bov1, (c <= 2));
      chk($sformatf("sof_vld3_c%0d", c), bov3, (c <= 4));
      chk($sformatf("sof_done1_c%0d", c), done1, (c == 4));
      chk($sformatf("sof_done3_c%0d", c), done3, (c == 8));
      tick();
    end
    chk("sof_fc1", fc1, 2);
    chk("sof_fc3", fc3, 4);
    chk("sof_ffa3", ffa3, 0);
    chk("sof_ffd3", ffd3, 4'h8);
    chk("sof_pass3", pass3, 0);
    chk("sof_ndone1", nd1, 1);
    chk("sof_ndone3", nd3, 1);

    // Mask 0x3 on vector 1 hides a bit-3 difference
    clear();
    for (int i = 0; i < 4; i++) load(4'(i + 1), 4'(i + 9), (i == 1) ? 4'h3 : 4'hF);
    mode = 3;
    go(1'b0);
    repeat (12) tick();
    chk("mask3_fc1", fc1, 0);
    chk("mask3_pass1", pass1, 1);
    chk("mask3_fc3", fc3, 0);
    // Same response with full mask fails
    clear();
    for (int i = 0; i < 4; i++) load(4'(i + 1), 4'(i + 9), 4'hF);
    go(1'b0);
    repeat (12) tick();
    chk("maskF_fc1", fc1, 1);
    chk("maskF_ffa1", ffa1, 1);
    chk("maskF_ffd1", ffd1, 4'h2);
    chk("maskF_pass1", pass1, 0);

    // Abort during run
    mode = 0;
    go(1'b0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy1", busy1, 0);
    chk("abort_busy3", busy3, 0);
    chk("abort_vld1", bov1, 0);
    chk("abort_pass1", pass1, 0);
    repeat (10) tick();
    chk("abort_ndone1", nd1, 0);
    chk("abort_ndone3", nd3, 0);

    // Fill, overflow, clear, empty start
    clear();
    for (int i = 0; i < 8; i++) load(4'(i), 4'(i), 4'hF);
    chk("full_vec_count", vc1, 8);
    chk("full_load_ready", lr1, 0);
    chk("full_overflow_pre", ovf1, 0);
    load(4'hE, 4'hE, 4'hF);
    chk("ovf_overflow", ovf1, 1);
    chk("ovf_vec_count", vc1, 8);
    clear();
    chk("clr_vec_count", vc1, 0);
    chk("clr_overflow", ovf1, 0);
    go(1'b0);
    chk("empty_done1", done1, 1);
    chk("empty_pass1", pass1, 1);
    chk("empty_done3", done3, 1);
    tick();

    // Reset mid-run
    for (int i = 0; i < 4; i++) load(4'(i + 1), 4'(i + 9), 4'hF);
    mode = 2;
    go(1'b0);
    tick(); tick();
    chk("midrst_pre_fc1", fc1, 1);
    chk("midrst_pre_busy1", busy1, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy1", busy1, 0);
    chk("midrst_busy3", busy3, 0);
    chk("midrst_vld1", bov1, 0);
    chk("midrst_out1", bo1, 0);
    chk("midrst_done1", done1, 0);
    chk("midrst_fc1", fc1_n, 0);
    chk("midrst_ffv1", ffv1, 0);
    chk("midrst_ffa1", ffa1, 0);
    chk("midrst_ffd1", ffd1, 0);
    chk("midrst_vec_count", vc1, 0);
    chk("midrst_pass1", pass1, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_ndone1", nd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
